// File: rtl/cache_4way_l1l2_system_pkg.sv
// Shared configuration for the two-level read-only cache: address/data widths,
// L1 and L2 index/tag split, L1 associativity and the backing ROM contents.
// No logic, so no latency; no flow control.
package cache_cfg_pkg;

    localparam int ADDR_WIDTH = 11;
    localparam int DATA_WIDTH = 32;

    localparam int L1_IDX_W   = 2;
    localparam int L1_TAG_W   = ADDR_WIDTH - L1_IDX_W;   // 9
    localparam int L1_SETS    = 1 << L1_IDX_W;           // 4
    localparam int L1_WAYS    = 4;

    localparam int L2_IDX_W   = 8;
    localparam int L2_TAG_W   = ADDR_WIDTH - L2_IDX_W;   // 3
    localparam int L2_LINES   = 1 << L2_IDX_W;           // 256

    // Backing store holds its own address, zero-extended to the word width.
    function automatic logic [DATA_WIDTH-1:0] rom_data(input logic [ADDR_WIDTH-1:0] a);
        return {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, a};
    endfunction

endpackage

// File: rtl/l1_4way_lru_set_array.sv
// 4-way set-associative L1 storage with age-based LRU: lookup, victim select, touch/fill.
// Lookup is combinational; touch/fill commits on the clock edge where read_i is high.
// No backpressure: every read_i cycle is accepted.
//
// Ports: clk/rst (async active-high), read_i (lookup strobe), set_i/tag_i (split address),
//        fill_data_i (word written into the victim on a miss), hit_o/hit_data_o (lookup result).
module l1_4way_lru_set_array
    import cache_cfg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_i,
    input  logic [L1_IDX_W-1:0]   set_i,
    input  logic [L1_TAG_W-1:0]   tag_i,
    input  logic [DATA_WIDTH-1:0] fill_data_i,
    output logic                  hit_o,
    output logic [DATA_WIDTH-1:0] hit_data_o
);

    logic                  valid_q [L1_SETS][L1_WAYS];
    logic [L1_TAG_W-1:0]   tag_q   [L1_SETS][L1_WAYS];
    logic [DATA_WIDTH-1:0] data_q  [L1_SETS][L1_WAYS];
    logic [1:0]            age_q   [L1_SETS][L1_WAYS];

    logic                  hit_c;
    logic [1:0]            hit_way;
    logic [DATA_WIDTH-1:0] hit_data_c;
    logic [1:0]            vict_way;
    logic                  vict_inv;
    logic                  vict_old;
    logic [1:0]            sel_way;
    logic [1:0]            old_age;

    always_comb begin
        hit_c      = 1'b0;
        hit_way    = 2'd0;
        hit_data_c = '0;
        vict_way   = 2'd0;
        vict_inv   = 1'b0;
        vict_old   = 1'b0;
        for (int w = 0; w < L1_WAYS; w++) begin
            if (!hit_c && valid_q[set_i][w] && tag_q[set_i][w] == tag_i) begin
                hit_c      = 1'b1;
                hit_way    = 2'(w);
                hit_data_c = data_q[set_i][w];
            end
        end
        // Lowest-index invalid way wins; only when the set is full fall back to age 3.
        for (int w = 0; w < L1_WAYS; w++) begin
            if (!vict_inv && !valid_q[set_i][w]) begin
                vict_inv = 1'b1;
                vict_way = 2'(w);
            end
        end
        if (!vict_inv) begin
            for (int w = 0; w < L1_WAYS; w++) begin
                if (!vict_old && age_q[set_i][w] == 2'd3) begin
                    vict_old = 1'b1;
                    vict_way = 2'(w);
                end
            end
        end
        sel_way = hit_c ? hit_way : vict_way;
        // Filling an empty way ages every other way below 3, as if it had been the LRU.
        if (hit_c)         old_age = age_q[set_i][hit_way];
        else if (vict_inv) old_age = 2'd3;
        else               old_age = age_q[set_i][vict_way];
    end

    assign hit_o      = hit_c;
    assign hit_data_o = hit_data_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < L1_SETS; s++) begin
                for (int w = 0; w < L1_WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    data_q[s][w]  <= '0;
                    age_q[s][w]   <= 2'(w);
                end
            end
        end else if (read_i) begin
            for (int w = 0; w < L1_WAYS; w++) begin
                if (2'(w) == sel_way)
                    age_q[set_i][w] <= 2'd0;
                else if (age_q[set_i][w] < old_age)
                    age_q[set_i][w] <= age_q[set_i][w] + 2'd1;
            end
            if (!hit_c) begin
                valid_q[set_i][sel_way] <= 1'b1;
                tag_q[set_i][sel_way]   <= tag_i;
                data_q[set_i][sel_way]  <= fill_data_i;
            end
        end
    end

endmodule

// File: rtl/cache_4way_l1l2_system.sv
// Read-only L1 (4-way LRU) + L2 (direct-mapped, non-inclusive) + ROM cache model.
// One-cycle: a read sampled at a rising edge resolves and updates outputs at that edge.
// No backpressure: one lookup per cycle with read high; outputs hold while read is low.
//
// Ports: clk, rst (async active-high), read (strobe), addr (word address),
//        read_data / l1_hit / l2_hit (registered result of the most recent read).
module cache_4way_l1l2_system
    import cache_cfg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  l1_hit,
    output logic                  l2_hit
);

    logic                  l2_valid_q [L2_LINES];
    logic [L2_TAG_W-1:0]   l2_tag_q   [L2_LINES];
    logic [DATA_WIDTH-1:0] l2_data_q  [L2_LINES];

    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                  l1_hit_q, l1_hit_d;
    logic                  l2_hit_q, l2_hit_d;

    logic [L2_IDX_W-1:0]   l2_idx;
    logic [L2_TAG_W-1:0]   l2_tag;
    logic                  l2_hit_c;
    logic                  l1_hit_c;
    logic [DATA_WIDTH-1:0] l1_data_c;
    logic [DATA_WIDTH-1:0] fill_data_c;
    logic                  l2_fill;

    assign l2_idx      = addr[L2_IDX_W-1:0];
    assign l2_tag      = addr[ADDR_WIDTH-1:L2_IDX_W];
    assign l2_hit_c    = l2_valid_q[l2_idx] && (l2_tag_q[l2_idx] == l2_tag);
    assign fill_data_c = l2_hit_c ? l2_data_q[l2_idx] : rom_data(addr);
    // L2 only allocates on a full miss; L1 hits leave L2 untouched.
    assign l2_fill     = read && !l1_hit_c && !l2_hit_c;

    l1_4way_lru_set_array u_l1 (
        .clk         (clk),
        .rst         (rst),
        .read_i      (read),
        .set_i       (addr[L1_IDX_W-1:0]),
        .tag_i       (addr[ADDR_WIDTH-1:L1_IDX_W]),
        .fill_data_i (fill_data_c),
        .hit_o       (l1_hit_c),
        .hit_data_o  (l1_data_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < L2_LINES; i++)
                l2_valid_q[i] <= 1'b0;
        end else if (l2_fill) begin
            l2_valid_q[l2_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are only consulted behind a valid bit.
    always_ff @(posedge clk) begin
        if (l2_fill) begin
            l2_tag_q[l2_idx]  <= l2_tag;
            l2_data_q[l2_idx] <= fill_data_c;
        end
    end

    always_comb begin
        read_data_d = read_data_q;
        l1_hit_d    = l1_hit_q;
        l2_hit_d    = l2_hit_q;
        if (read) begin
            l1_hit_d    = l1_hit_c;
            l2_hit_d    = !l1_hit_c && l2_hit_c;
            read_data_d = l1_hit_c ? l1_data_c : fill_data_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_q <= '0;
            l1_hit_q    <= 1'b0;
            l2_hit_q    <= 1'b0;
        end else begin
            read_data_q <= read_data_d;
            l1_hit_q    <= l1_hit_d;
            l2_hit_q    <= l2_hit_d;
        end
    end

    assign read_data = read_data_q;
    assign l1_hit    = l1_hit_q;
    assign l2_hit    = l2_hit_q;

endmodule

// File: tb/tb_cache_4way_l1l2_system.sv
module tb_cache_4way_l1l2_system;

    logic        clk;
    logic        rst;
    logic        read;
    logic [10:0] addr;
    logic [31:0] read_data;
    logic        l1_hit;
    logic        l2_hit;

    int checks = 0;
    int errors = 0;
    int n_l1   = 0;
    int n_l2   = 0;

    cache_4way_l1l2_system dut (
        .clk       (clk),
        .rst       (rst),
        .read      (read),
        .addr      (addr),
        .read_data (read_data),
        .l1_hit    (l1_hit),
        .l2_hit    (l2_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want done");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Issue one read from a negedge, sample the registered result at the next negedge.
    task automatic rd(input string tag, input logic [10:0] a,
                      input logic [31:0] exp_data, input logic exp_l1, input logic exp_l2);
        read = 1'b1;
        addr = a;
        @(negedge clk);
        chk({tag, ".data"}, read_data, exp_data);
        chk({tag, ".l1"},   {31'b0, l1_hit}, {31'b0, exp_l1});
        chk({tag, ".l2"},   {31'b0, l2_hit}, {31'b0, exp_l2});
        n_l1 += int'(l1_hit);
        n_l2 += int'(l2_hit);
        read = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        read = 1'b0;
        addr = '0;
        #1;
        chk("rst.data", read_data, 32'h0);
        chk("rst.l1",   {31'b0, l1_hit}, 32'h0);
        chk("rst.l2",   {31'b0, l2_hit}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Cold read, then outputs must hold across idle cycles.
        rd("r020a", 11'h020, 32'h020, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("hold.data", read_data, 32'h020);
        chk("hold.l1",   {31'b0, l1_hit}, 32'h0);
        chk("hold.l2",   {31'b0, l2_hit}, 32'h0);

        // Set-0 warm sequence exercising LRU eviction and L2 refill.
        rd("r040a", 11'h040, 32'h040, 1'b0, 1'b0);
        rd("r060a", 11'h060, 32'h060, 1'b0, 1'b0);
        rd("r020b", 11'h020, 32'h020, 1'b1, 1'b0);
        rd("r080a", 11'h080, 32'h080, 1'b0, 1'b0);
        rd("r0a0a", 11'h0a0, 32'h0a0, 1'b0, 1'b0);
        rd("r040b", 11'h040, 32'h040, 1'b0, 1'b1);
        rd("r0c0a", 11'h0c0, 32'h0c0, 1'b0, 1'b0);
        rd("r0e0a", 11'h0e0, 32'h0e0, 1'b0, 1'b0);
        rd("r020c", 11'h020, 32'h020, 1'b0, 1'b1);
        chk("tot.l1", n_l1, 32'd1);
        chk("tot.l2", n_l2, 32'd2);

        // L2 conflict: 0x120 overwrites L2 line 0x20, L1 still keeps 0x020.
        rd("r120a", 11'h120, 32'h120, 1'b0, 1'b0);
        rd("r020d", 11'h020, 32'h020, 1'b1, 1'b0);
        rd("r120b", 11'h120, 32'h120, 1'b1, 1'b0);

        // Back-to-back reads of the top address (read stays high across both edges).
        rd("r7ffa", 11'h7ff, 32'h7ff, 1'b0, 1'b0);
        rd("r7ffb", 11'h7ff, 32'h7ff, 1'b1, 1'b0);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst.data", read_data, 32'h0);
        chk("arst.l1",   {31'b0, l1_hit}, 32'h0);
        chk("arst.l2",   {31'b0, l2_hit}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rd("r020e", 11'h020, 32'h020, 1'b0, 1'b0);
        rd("r040c", 11'h040, 32'h040, 1'b0, 1'b0);
        rd("r020f", 11'h020, 32'h020, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
